// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types: FSM state encoding and default parameter widths.
// Pure declarations; no latency and no backpressure.
package pipeline_ctrl_pkg;

    localparam int DEF_W  = 5;
    localparam int DEF_CW = 32;
    localparam int DEF_SW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    function automatic logic is_advance(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard compare between ID/EX load destination and IF/ID sources; purely combinational.
// Latency: zero; no backpressure, the result is only meaningful while the pipeline advances.
module load_use_detect #(
    parameter int W = 5
) (
    input  logic         id_ex_memread_i,
    input  logic [W-1:0] id_ex_rt_i,
    input  logic [W-1:0] if_id_rs_i,
    input  logic [W-1:0] if_id_rt_i,
    output logic         hazard_o
);

    logic rt_nonzero;
    logic src_match;

    // r0 is hardwired to zero, so a load targeting it can never feed a consumer.
    assign rt_nonzero = (id_ex_rt_i != '0);
    assign src_match  = (id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i);
    assign hazard_o   = id_ex_memread_i && rt_nonzero && src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/step/halt control FSM driving pipeline latch enables, load-use bubble insertion and counters.
// Latency: enables are zero-latency from registered state; stall freezes PC and IF/ID and bubbles ID/EX.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW,
    parameter int SW = DEF_SW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run_mode,
    input  logic          step_req,
    input  logic          halt_in,
    input  logic          id_ex_memread,
    input  logic [W-1:0]  id_ex_rt,
    input  logic [W-1:0]  if_id_rs,
    input  logic [W-1:0]  if_id_rt,
    output logic          pc_ena,
    output logic          if_id_ena,
    output logic          id_ex_ena,
    output logic          ex_mem_ena,
    output logic          mem_wb_ena,
    output logic          id_ex_flush,
    output logic [1:0]    state,
    output logic          halted,
    output logic [CW-1:0] cycle_count,
    output logic [SW-1:0] stall_count
);

    state_e        state_q, state_d;
    logic [CW-1:0] cycle_q, cycle_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          hazard;
    logic          advance;

    load_use_detect #(.W(W)) u_lud (
        .id_ex_memread_i (id_ex_memread),
        .id_ex_rt_i      (id_ex_rt),
        .if_id_rs_i      (if_id_rs),
        .if_id_rt_i      (if_id_rt),
        .hazard_o        (hazard)
    );

    assign advance = is_advance(state_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run_mode)      state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (halt_in)       state_d = ST_HALTED;
                else if (!run_mode) state_d = ST_IDLE;
            end
            ST_STEP: begin
                state_d = halt_in ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_ena      = 1'b0;
        if_id_ena   = 1'b0;
        id_ex_ena   = 1'b0;
        ex_mem_ena  = 1'b0;
        mem_wb_ena  = 1'b0;
        id_ex_flush = 1'b0;
        cycle_d     = cycle_q;
        stall_d     = stall_q;
        if (advance) begin
            // On a load-use hazard the front end holds while a bubble drains into EX.
            pc_ena      = !hazard;
            if_id_ena   = !hazard;
            id_ex_ena   = 1'b1;
            ex_mem_ena  = 1'b1;
            mem_wb_ena  = 1'b1;
            id_ex_flush = hazard;
            cycle_d     = cycle_q + CW'(1);
            if (hazard && (stall_q != {SW{1'b1}})) begin
                stall_d = stall_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            stall_q <= stall_d;
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == ST_HALTED);
    assign cycle_count = cycle_q;
    assign stall_count = stall_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter W, default 5, register-address width.
REQ-002 Parameter CW, default 32, cycle-counter width.
REQ-003 Parameter SW, default 16, stall-counter width.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 run_mode  input  1  level; 1 = free-running execution requested.
REQ-007 step_req  input  1  single-cycle pulse; request one pipeline advance.
REQ-008 halt_in  input  1  HALT instruction has reached write-back.
REQ-009 id_ex_memread  input  1  instruction in ID/EX is a load.
REQ-010 id_ex_rt  input  W  load destination register in ID/EX.
REQ-011 if_id_rs, if_id_rt  input  W each  source registers of the instruction in IF/ID.
REQ-012 pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena  output  1 each  latch enables.
REQ-013 id_ex_flush  output  1  zero all control signals loaded into ID/EX (bubble).
REQ-014 state  output  2  current FSM state.
REQ-015 halted  output  1  1 while state = HALTED.
REQ-016 cycle_count  output  CW  number of advance cycles since reset.
REQ-017 stall_count  output  SW  number of load-use stall cycles since reset.

Function
REQ-018 FSM states: IDLE=0, RUN=1, STEP=2, HALTED=3.
REQ-019 IDLE: run_mode=1 -> RUN; else step_req=1 -> STEP; else stay; run_mode has priority over step_req.
REQ-020 RUN: halt_in=1 -> HALTED; else run_mode=0 -> IDLE; else stay.
REQ-021 STEP: halt_in=1 -> HALTED; else -> IDLE unconditionally (exactly one advance cycle per step_req).
REQ-022 HALTED: absorbing; exit only via reset; step_req and run_mode ignored.
REQ-023 step_req outside IDLE is ignored, not queued.
REQ-024 "Advance" = state is RUN or STEP; enables are combinational from registered state and hazard inputs (zero latency within the cycle).
REQ-025 Hazard = id_ex_memread & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt).
REQ-026 Advance without hazard: all five enables = 1, id_ex_flush = 0.
REQ-027 Advance with hazard: pc_ena = if_id_ena = 0; id_ex_ena = ex_mem_ena = mem_wb_ena = 1; id_ex_flush = 1.
REQ-028 Not advancing (IDLE, HALTED): all enables = 0, id_ex_flush = 0; hazard inputs ignored.
REQ-029 In the cycle halt_in is seen during advance, enables follow REQ-026/027 (that cycle still advances); next cycle HALTED.
REQ-030 cycle_count increments by 1 every advance cycle, wraps modulo 2^CW.
REQ-031 stall_count increments every advance cycle with hazard, saturates at 2^SW-1.
REQ-032 Register 0 never causes a stall, even when id_ex_memread = 1.

Reset
REQ-033 On reset: state = IDLE, halted = 0, cycle_count = 0, stall_count = 0; consequently all enables and id_ex_flush = 0.
REQ-034 Reset has priority over every other input, including mid-RUN, mid-STEP and HALTED.

Structure
REQ-035 State encodings and default widths live in the shared pipeline package.
REQ-036 Hazard comparison is one combinational sub-module, load_use_detect; FSM and counters stay in pipeline_ctrl.

Verification
REQ-037 Reset, run_mode=0, step_req=0 for 10 cycles -> all enables 0, state=0, cycle_count=0.
REQ-038 In IDLE, three step_req pulses 4 cycles apart -> exactly three single cycles with all enables 1, cycle_count=3.
REQ-039 RUN, id_ex_memread=1, id_ex_rt=5, if_id_rs=5 for one cycle -> pc_ena=0, if_id_ena=0, id_ex_flush=1, other enables 1, stall_count=1; same with id_ex_rt=0 -> no stall.
REQ-040 RUN, halt_in pulse at cycle 20 -> enables 1 at cycle 20, state=3 and enables 0 from cycle 21; later run_mode/step_req -> no change.
REQ-041 run_mode=1 and step_req=1 same cycle in IDLE -> state=RUN; reset asserted while RUN with cycle_count=7 -> next cycle state=IDLE, cycle_count=0.
REQ-042 Force stall_count to 2^SW-1, hazard again -> stays 2^SW-1; cycle_count at 2^CW-1, advance -> wraps to 0.
